// File: rtl/apb_timer.sv
// APB3 slave up-counter timer: STATUS/GOAL/CURR at word offsets 0/1/2.
// Counts at clk/PRESCALE once started and pulses irq for one cycle when CURR reaches GOAL.
module apb_timer #(
   parameter int ADDR_W      = 2,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int PRESCALE    = 1
) (
   input  logic              clk,
   input  logic              preset,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              irq
);

   localparam logic [1:0] A_IDLE   = 2'd0;
   localparam logic [1:0] A_SETUP  = 2'd1;
   localparam logic [1:0] A_ACCESS = 2'd2;
   localparam logic [1:0] A_RESP   = 2'd3;

   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_RUN    = 2'd1;
   localparam logic [1:0] T_DONE   = 2'd2;
   localparam logic [1:0] T_PAUSE  = 2'd3;

   localparam int         PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
   localparam logic [2:0] WS     = 3'(WAIT_STATES);

   logic [1:0]        apb_st;
   logic [2:0]        wcnt;
   logic [1:0]        tstate;
   logic [DATA_W-1:0] goal;
   logic [DATA_W-1:0] curr;
   logic [PW-1:0]     presc;
   logic [DATA_W-1:0] rd_data;
   logic              fire;
   logic              pwrite_bad;
   logic              wr_ok;
   logic              cmd_start;
   logic              cmd_stop;

   // CURR may only climb up to all-ones; GOAL is what normally stops it.
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == '1) ? v : v + DATA_W'(1);
   endfunction

   // The transfer completes on the edge that raises pready; all side effects happen there.
   assign fire = psel && penable &&
                 (((apb_st == A_SETUP) && (WS == 3'd0)) ||
                  ((apb_st == A_ACCESS) && (wcnt == WS)));

   assign pwrite_bad = !((pwrite === 1'b1) || (pwrite === 1'b0));
   assign wr_ok      = fire && !pwrite_bad && pwrite;
   assign cmd_start  = wr_ok && (paddr == ADDR_W'(0)) && pwdata[0];
   assign cmd_stop   = wr_ok && (paddr == ADDR_W'(0)) && pwdata[1];

   always_comb begin
      rd_data = '0;
      if (paddr == ADDR_W'(0))      rd_data[3:2] = tstate;
      else if (paddr == ADDR_W'(1)) rd_data = goal;
      else if (paddr == ADDR_W'(2)) rd_data = curr;
   end

   always_ff @(posedge clk) begin
      if (preset) begin
         apb_st  <= A_IDLE;
         wcnt    <= '0;
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
      end else begin
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
         if (fire) begin
            apb_st  <= A_RESP;
            pready  <= 1'b1;
            pslverr <= pwrite_bad;
            prdata  <= (pwrite_bad || pwrite) ? '0 : rd_data;
         end else begin
            case (apb_st)
               A_IDLE:   if (psel && !penable) apb_st <= A_SETUP;
               A_SETUP: begin
                  if (!psel) begin
                     apb_st <= A_IDLE;
                  end else if (penable) begin
                     apb_st <= A_ACCESS;
                     wcnt   <= 3'd1;
                  end
               end
               A_ACCESS: begin
                  if (!(psel && penable)) apb_st <= A_IDLE;
                  else                    wcnt   <= wcnt + 3'd1;
               end
               default:  apb_st <= A_IDLE;
            endcase
         end
      end
   end

   // Timer: STOP beats START; a START while already running is a no-op.
   always_ff @(posedge clk) begin
      if (preset) begin
         tstate <= T_IDLE;
         goal   <= '0;
         curr   <= '0;
         presc  <= '0;
         irq    <= 1'b0;
      end else begin
         irq <= 1'b0;
         if (wr_ok && (paddr == ADDR_W'(1))) goal <= pwdata;
         if (cmd_stop) begin
            if (tstate == T_RUN) tstate <= T_PAUSE;
         end else if (cmd_start && (tstate != T_RUN)) begin
            tstate <= T_RUN;
            if (tstate != T_PAUSE) begin
               curr  <= '0;
               presc <= '0;
            end
         end else if (tstate == T_RUN) begin
            if (curr >= goal) begin
               tstate <= T_DONE;
               irq    <= 1'b1;
            end else if (presc == PS_MAX) begin
               presc <= '0;
               curr  <= sat_inc(curr);
               if (sat_inc(curr) == goal) begin
                  tstate <= T_DONE;
                  irq    <= 1'b1;
               end
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: stimulus pushes expected responses, a monitor pops them on pready.
module tb_apb_timer;

   logic       clk = 1'b0;
   logic       preset;
   logic [1:0] paddr;
   logic       pwrite, psel, penable;
   logic [7:0] pwdata, prdata;
   logic       pready, pslverr, irq;

   logic [1:0] paddr2;
   logic       pwrite2, psel2, penable2;
   logic [7:0] pwdata2, prdata2;
   logic       pready2, pslverr2, irq2;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int last_fire = 0;

   typedef struct {
      logic [7:0] d;
      logic       e;
      string      nm;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_timer #(.ADDR_W(2), .DATA_W(8), .WAIT_STATES(0), .PRESCALE(1)) u_dut (
      .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel),
      .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .irq(irq));

   apb_timer #(.ADDR_W(2), .DATA_W(8), .WAIT_STATES(3), .PRESCALE(1)) u_ws3 (
      .clk(clk), .preset(preset), .paddr(paddr2), .pwrite(pwrite2), .psel(psel2),
      .penable(penable2), .pwdata(pwdata2), .prdata(prdata2), .pready(pready2),
      .pslverr(pslverr2), .irq(irq2));

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Monitor: every pready must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (pready) begin
         exp_t x;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pready: got prdata=%0d, expected no transfer", prdata);
         end else begin
            x = exp_q.pop_front();
            check({x.nm, "_prdata"}, int'(prdata), int'(x.d));
            check({x.nm, "_pslverr"}, int'(pslverr), int'(x.e));
         end
      end else if (prdata != 8'd0) begin
         total++;
         bad++;
         $display("FAIL prdata_idle: got %0d, expected 0 while pready=0", prdata);
      end
   end

   task automatic apb(input logic [1:0] a, input logic w, input logic [7:0] wd,
                      input logic [7:0] ed, input logic ee, input string nm);
      bit got;
      got = 1'b0;
      exp_q.push_back('{ed, ee, nm});
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (pready) begin
            got = 1'b1;
            last_fire = cyc;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no pready, expected one within 20 clk", nm);
         exp_q.delete(exp_q.size() - 1);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic wait_irq(input int exp_at, input string nm);
      int at;
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (irq) begin
            at = cyc;
            break;
         end
      end
      check({nm, "_irq_cycle"}, at, exp_at);
      @(negedge clk);
      check({nm, "_irq_width"}, int'(irq), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      int f, s, r, g, p, cnt, st, at, exp_goal;
      logic pw_x;
      bit four_state;

      preset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
      psel2 = 1'b0; penable2 = 1'b0; paddr2 = '0; pwrite2 = 1'b0; pwdata2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pready", int'(pready), 0);
      check("rst_prdata", int'(prdata), 0);
      check("rst_pslverr", int'(pslverr), 0);
      check("rst_irq", int'(irq), 0);
      @(posedge clk); #1;
      preset = 1'b0;

      // Basic run to GOAL=25
      apb(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, "rd_status_rst");
      apb(2'd1, 1'b1, 8'd25, 8'h00, 1'b0, "wr_goal");
      apb(2'd1, 1'b0, 8'h00, 8'd25, 1'b0, "rd_goal");
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_start");
      f = last_fire;
      apb(2'd0, 1'b0, 8'h00, 8'h04, 1'b0, "rd_status_run");
      wait_irq(f + 25, "run25");
      apb(2'd0, 1'b0, 8'h00, 8'h08, 1'b0, "rd_status_done");
      apb(2'd2, 1'b0, 8'h00, 8'd25, 1'b0, "rd_curr_done");

      // Pause and resume
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_restart");
      f = last_fire;
      repeat (5) @(posedge clk);
      apb(2'd0, 1'b1, 8'h03, 8'h00, 1'b0, "wr_startstop");
      s = last_fire;
      p = s - f - 1;
      apb(2'd0, 1'b0, 8'h00, 8'h0C, 1'b0, "rd_status_pause");
      apb(2'd2, 1'b0, 8'h00, 8'(p), 1'b0, "rd_curr_pause1");
      repeat (10) @(posedge clk);
      apb(2'd2, 1'b0, 8'h00, 8'(p), 1'b0, "rd_curr_pause2");
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_resume");
      r = last_fire;
      wait_irq(r + 25 - p, "resume");
      apb(2'd2, 1'b0, 8'h00, 8'd25, 1'b0, "rd_curr_resume");

      // Unmapped offset
      apb(2'd3, 1'b1, 8'h55, 8'h00, 1'b0, "wr_unmapped");
      apb(2'd3, 1'b0, 8'h00, 8'h00, 1'b0, "rd_unmapped");
      apb(2'd0, 1'b0, 8'h00, 8'h08, 1'b0, "rd_status_unm");
      apb(2'd1, 1'b0, 8'h00, 8'd25, 1'b0, "rd_goal_unm");

      // psel alone, then penable alone
      cnt = 0;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 2'd1; pwrite = 1'b1; pwdata = 8'd77;
      repeat (4) begin @(negedge clk); if (pready) cnt++; end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b1;
      repeat (4) begin @(negedge clk); if (pready) cnt++; end
      @(posedge clk); #1;
      penable = 1'b0; pwrite = 1'b0;
      check("noaccess_pready", cnt, 0);
      apb(2'd1, 1'b0, 8'h00, 8'd25, 1'b0, "rd_goal_noacc");

      // pwrite=X: a four-state simulator flags it; a two-state one sees a plain 0/1
      pw_x = 1'bx;
      four_state = (pw_x === 1'bx);
      exp_goal = (four_state || !pw_x) ? 25 : 99;
      apb(2'd1, pw_x, 8'd99, (four_state || pw_x) ? 8'h00 : 8'd25, four_state, "xwrite");
      apb(2'd1, 1'b0, 8'h00, 8'(exp_goal), 1'b0, "rd_goal_x");

      // GOAL lowered below CURR while running
      apb(2'd1, 1'b1, 8'd200, 8'h00, 1'b0, "wr_goal200");
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_start200");
      f = last_fire;
      repeat (3) @(posedge clk);
      apb(2'd1, 1'b1, 8'd2, 8'h00, 1'b0, "wr_goal_low");
      g = last_fire;
      wait_irq(g + 1, "goal_low");
      apb(2'd2, 1'b0, 8'h00, 8'(g - f), 1'b0, "rd_curr_low");

      // GOAL=0 completes immediately
      apb(2'd1, 1'b1, 8'd0, 8'h00, 1'b0, "wr_goal0");
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_start0");
      f = last_fire;
      wait_irq(f + 1, "goal0");
      apb(2'd2, 1'b0, 8'h00, 8'd0, 1'b0, "rd_curr0");
      apb(2'd0, 1'b0, 8'h00, 8'h08, 1'b0, "rd_status0");

      // Reset mid-count
      apb(2'd1, 1'b1, 8'd200, 8'h00, 1'b0, "wr_goal_rst");
      apb(2'd0, 1'b1, 8'h01, 8'h00, 1'b0, "wr_start_rst");
      repeat (5) @(posedge clk);
      #1 preset = 1'b1;
      @(negedge clk);
      check("midrst_pready", int'(pready), 0);
      check("midrst_prdata", int'(prdata), 0);
      check("midrst_irq", int'(irq), 0);
      @(posedge clk); #1;
      preset = 1'b0;
      apb(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, "rd_status_midrst");
      apb(2'd1, 1'b0, 8'h00, 8'h00, 1'b0, "rd_goal_midrst");
      apb(2'd2, 1'b0, 8'h00, 8'h00, 1'b0, "rd_curr_midrst");

      // WAIT_STATES=3 instance: pready 4 clk after the SETUP edge
      at = -1;
      @(posedge clk); #1;
      psel2 = 1'b1; paddr2 = 2'd0; pwrite2 = 1'b0;
      @(posedge clk); #1;
      st = cyc;
      penable2 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (pready2) begin
            at = cyc - st;
            check("ws3_prdata", int'(prdata2), 0);
            check("ws3_pslverr", int'(pslverr2), 0);
            break;
         end
      end
      check("ws3_latency", at, 4);
      @(posedge clk); #1;
      psel2 = 1'b0; penable2 = 1'b0;
      check("ws3_irq", int'(irq2), 0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
